// File: rtl/wb_stage.sv
// Writeback stage: retires instructions from the memory stage, waits for the load response on loads,
// extends the load lane and drives the register-file write port, commit pulse and retire counter.
module wb_stage #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [4:0]       in_rd,
  input  logic             in_rd_we,
  input  logic [XLEN-1:0]  in_result,
  input  logic             in_is_load,
  input  logic [1:0]       in_ld_size,
  input  logic             in_ld_unsigned,
  input  logic [2:0]       in_addr_lo,
  input  logic             mem_rvalid,
  input  logic [XLEN-1:0]  mem_rdata,
  output logic             we_o,
  output logic [4:0]       waddr_o,
  output logic [XLEN-1:0]  wdata_o,
  output logic             commit_o,
  output logic [XLEN-1:0]  commit_pc_o,
  output logic [CNT_W-1:0] retire_cnt_o,
  output logic             err_o
);

  typedef enum logic [0:0] {IDLE, WAIT_LOAD} state_t;

  state_t            r_state, w_state_nxt;
  logic [4:0]        r_rd;
  logic              r_rd_we;
  logic [1:0]        r_size;
  logic              r_uns;
  logic [2:0]        r_addr;
  logic [XLEN-1:0]   r_pc;
  logic [15:0]       r_tcnt;
  logic              r_err;
  logic              r_we, r_commit;
  logic [4:0]        r_waddr;
  logic [XLEN-1:0]   r_wdata, r_commit_pc;
  logic [CNT_W-1:0]  r_retire_cnt;

  logic              w_accept;
  logic [15:0]       w_tcnt_inc;
  logic              w_timeout;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_word;
  logic [XLEN-1:0]   w_ld_data;

  assign in_ready     = (r_state == IDLE);
  assign w_accept     = in_valid & in_ready;
  assign w_tcnt_inc   = r_tcnt + 16'd1;
  assign w_timeout    = (w_tcnt_inc == 16'(TIMEOUT));

  // Low address bits beyond the natural lane are dropped by the slice index.
  assign w_byte = mem_rdata[{r_addr, 3'b000} +: 8];
  assign w_half = mem_rdata[{r_addr[2:1], 4'b0000} +: 16];
  assign w_word = mem_rdata[{r_addr[2], 5'b00000} +: 32];

  always_comb begin
    w_ld_data = mem_rdata;
    case (r_size)
      2'd0:    w_ld_data = {{(XLEN-8){~r_uns & w_byte[7]}}, w_byte};
      2'd1:    w_ld_data = {{(XLEN-16){~r_uns & w_half[15]}}, w_half};
      2'd2:    w_ld_data = {{(XLEN-32){~r_uns & w_word[31]}}, w_word};
      default: w_ld_data = mem_rdata;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:      if (w_accept && in_is_load) w_state_nxt = WAIT_LOAD;
      WAIT_LOAD: if (mem_rvalid || w_timeout) w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd         <= '0;
      r_rd_we      <= 1'b0;
      r_size       <= '0;
      r_uns        <= 1'b0;
      r_addr       <= '0;
      r_pc         <= '0;
      r_tcnt       <= '0;
      r_err        <= 1'b0;
      r_we         <= 1'b0;
      r_commit     <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_commit_pc  <= '0;
      r_retire_cnt <= '0;
    end else begin
      r_we     <= 1'b0;
      r_commit <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept && !in_is_load) begin
            r_we         <= in_rd_we & (in_rd != 5'd0);
            r_waddr      <= in_rd;
            r_wdata      <= in_result;
            r_commit     <= 1'b1;
            r_commit_pc  <= in_pc;
            r_retire_cnt <= r_retire_cnt + 1'b1;
          end else if (w_accept) begin
            r_rd    <= in_rd;
            r_rd_we <= in_rd_we;
            r_size  <= in_ld_size;
            r_uns   <= in_ld_unsigned;
            r_addr  <= in_addr_lo;
            r_pc    <= in_pc;
            r_tcnt  <= '0;
          end
        end
        WAIT_LOAD: begin
          if (mem_rvalid) begin
            r_we         <= r_rd_we & (r_rd != 5'd0);
            r_waddr      <= r_rd;
            r_wdata      <= w_ld_data;
            r_commit     <= 1'b1;
            r_commit_pc  <= r_pc;
            r_retire_cnt <= r_retire_cnt + 1'b1;
          end else begin
            r_tcnt <= w_tcnt_inc;
            if (w_timeout) r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign we_o         = r_we;
  assign waddr_o      = r_waddr;
  assign wdata_o      = r_wdata;
  assign commit_o     = r_commit;
  assign commit_pc_o  = r_commit_pc;
  assign retire_cnt_o = r_retire_cnt;
  assign err_o        = r_err;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus pushes expected commits, a negedge monitor pops and compares.
module tb_wb_stage;

  localparam int unsigned XLEN = 64;
  localparam int unsigned TO   = 12;
  localparam int unsigned CW   = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready;
  logic [63:0]     in_pc, in_result, mem_rdata;
  logic [4:0]      in_rd;
  logic            in_rd_we, in_is_load, in_ld_unsigned, mem_rvalid;
  logic [1:0]      in_ld_size;
  logic [2:0]      in_addr_lo;
  logic            we_o, commit_o, err_o;
  logic [4:0]      waddr_o;
  logic [63:0]     wdata_o, commit_pc_o, retire_cnt_o;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic [63:0] pc;
    logic [63:0] cnt;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad   = 0;
  logic [63:0] exp_cnt = 0;

  wb_stage #(.XLEN(XLEN), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_rd(in_rd),
    .in_rd_we(in_rd_we), .in_result(in_result), .in_is_load(in_is_load),
    .in_ld_size(in_ld_size), .in_ld_unsigned(in_ld_unsigned), .in_addr_lo(in_addr_lo),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o), .commit_o(commit_o),
    .commit_pc_o(commit_pc_o), .retire_cnt_o(retire_cnt_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push(input logic we, input logic [4:0] rd, input logic [63:0] d, input logic [63:0] pc);
    exp_t e;
    exp_cnt = exp_cnt + 1;
    e.we = we; e.waddr = rd; e.wdata = d; e.pc = pc; e.cnt = exp_cnt;
    q.push_back(e);
  endtask

  // Monitor: every commit must match the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (commit_o) begin
          if (q.size() == 0) chk("unexpected_commit", 64'(commit_o), 64'd0);
          else begin
            e = q.pop_front();
            chk("we", 64'(we_o), 64'(e.we));
            chk("waddr", 64'(waddr_o), 64'(e.waddr));
            chk("wdata", wdata_o, e.wdata);
            chk("commit_pc", commit_pc_o, e.pc);
            chk("retire_cnt", retire_cnt_o, e.cnt);
          end
        end else if (we_o) chk("we_without_commit", 64'(we_o), 64'd0);
      end
    end
  end

  task automatic idle_in();
    in_valid = 0; in_pc = '0; in_rd = '0; in_rd_we = 0; in_result = '0;
    in_is_load = 0; in_ld_size = '0; in_ld_unsigned = 0; in_addr_lo = '0;
  endtask

  // Presents one ALU op; leaves inputs driven so calls can be back-to-back.
  task automatic alu(input logic [63:0] pc, input logic [4:0] rd, input logic we, input logic [63:0] res);
    chk("ready_alu", 64'(in_ready), 64'd1);
    in_valid = 1; in_is_load = 0; in_pc = pc; in_rd = rd; in_rd_we = we; in_result = res;
    push(we & (rd != 0), rd, res, pc);
    @(negedge clk);
  endtask

  task automatic load(input logic [63:0] pc, input logic [4:0] rd, input logic [1:0] sz,
                      input logic uns, input logic [2:0] a, input logic [63:0] rdata,
                      input int dly, input logic [63:0] exp_d);
    chk("ready_load", 64'(in_ready), 64'd1);
    in_valid = 1; in_is_load = 1; in_pc = pc; in_rd = rd; in_rd_we = 1;
    in_ld_size = sz; in_ld_unsigned = uns; in_addr_lo = a;
    push(rd != 0, rd, exp_d, pc);
    @(negedge clk);
    idle_in();
    for (int i = 0; i < dly; i++) begin
      chk("ready_wait", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    mem_rvalid = 1; mem_rdata = rdata;
    @(negedge clk);
    mem_rvalid = 0; mem_rdata = '0;
    chk("ready_after_load", 64'(in_ready), 64'd1);
  endtask

  initial begin
    rst = 1; mem_rvalid = 0; mem_rdata = '0;
    idle_in();
    repeat (3) @(negedge clk);
    rst = 0;
    chk("rst_we", 64'(we_o), 0);
    chk("rst_waddr", 64'(waddr_o), 0);
    chk("rst_wdata", wdata_o, 0);
    chk("rst_commit", 64'(commit_o), 0);
    chk("rst_pc", commit_pc_o, 0);
    chk("rst_cnt", retire_cnt_o, 0);
    chk("rst_err", 64'(err_o), 0);
    chk("rst_ready", 64'(in_ready), 1);

    alu(64'h8000_0000, 5'd5, 1, 64'h1234);
    idle_in();
    @(negedge clk);
    alu(64'h8000_0004, 5'd1, 1, 64'h11);
    alu(64'h8000_0008, 5'd2, 1, 64'h22);
    alu(64'h8000_000C, 5'd3, 1, 64'h33);
    idle_in();
    @(negedge clk);
    chk("cnt_after_b2b", retire_cnt_o, 64'd4);

    load(64'h100, 5'd7,  2'd0, 0, 3'd3, 64'h0000_0000_8000_0000, 0, 64'hFFFF_FFFF_FFFF_FF80);
    load(64'h104, 5'd8,  2'd0, 1, 3'd3, 64'h0000_0000_8000_0000, 1, 64'h80);
    load(64'h108, 5'd9,  2'd2, 0, 3'd4, 64'h8765_4321_0000_0000, 2, 64'hFFFF_FFFF_8765_4321);
    load(64'h10C, 5'd10, 2'd1, 0, 3'd7, 64'hBEEF_0000_0000_0000, 0, 64'hFFFF_FFFF_FFFF_BEEF);
    load(64'h110, 5'd11, 2'd1, 1, 3'd2, 64'h0000_0000_9876_0000, 0, 64'h9876);
    load(64'h114, 5'd12, 2'd3, 0, 3'd5, 64'hF123_4567_89AB_CDEF, 1, 64'hF123_4567_89AB_CDEF);
    load(64'h118, 5'd13, 2'd0, 0, 3'd6, 64'h007F_0000_0000_0000, 0, 64'h7F);
    load(64'h11C, 5'd0,  2'd3, 0, 3'd0, 64'hDEAD_BEEF_0000_0001, 0, 64'hDEAD_BEEF_0000_0001);
    alu(64'h120, 5'd0, 1, 64'h55);
    alu(64'h124, 5'd6, 0, 64'h66);
    idle_in();
    @(negedge clk);
    chk("cnt_after_loads", retire_cnt_o, exp_cnt);

    // Timeout: no response for TO cycles.
    chk("ready_to", 64'(in_ready), 1);
    in_valid = 1; in_is_load = 1; in_rd = 5'd14; in_rd_we = 1; in_pc = 64'h200;
    @(negedge clk);
    idle_in();
    repeat (TO - 1) @(negedge clk);
    chk("err_before_to", 64'(err_o), 0);
    chk("ready_before_to", 64'(in_ready), 0);
    @(negedge clk);
    chk("err_at_to", 64'(err_o), 1);
    chk("ready_at_to", 64'(in_ready), 1);
    mem_rvalid = 1; mem_rdata = 64'h1;
    @(negedge clk);
    mem_rvalid = 0;
    @(negedge clk);
    chk("cnt_after_to", retire_cnt_o, exp_cnt);

    load(64'h300, 5'd15, 2'd3, 0, 3'd0, 64'h0123, 0, 64'h0123);
    chk("err_sticky", 64'(err_o), 1);

    // Reset while waiting for a load abandons it.
    in_valid = 1; in_is_load = 1; in_rd = 5'd16; in_rd_we = 1; in_pc = 64'h400;
    @(negedge clk);
    idle_in();
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    exp_cnt = 0;
    mem_rvalid = 1; mem_rdata = 64'hFFFF;
    @(negedge clk);
    mem_rvalid = 0;
    @(negedge clk);
    chk("rr_we", 64'(we_o), 0);
    chk("rr_commit", 64'(commit_o), 0);
    chk("rr_wdata", wdata_o, 0);
    chk("rr_pc", commit_pc_o, 0);
    chk("rr_cnt", retire_cnt_o, 0);
    chk("rr_err", 64'(err_o), 0);
    chk("rr_ready", 64'(in_ready), 1);

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
